// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, 1-entry output buffer and skid.
// Define FETCH_STAT_EN to add fetch/wait statistics counters.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall_if,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
`ifdef FETCH_STAT_EN
    output logic [31:0] stat_fetch_cnt,
    output logic [31:0] stat_wait_cnt,
`endif
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid_if,
    output logic [31:0] inst_if,
    output logic [31:0] pc_if,
    output logic [31:0] pc_add4_if
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SKID,
        DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] opc_q, opc_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        consume;
    logic        free;
    logic [31:0] tgt;

    assign consume = valid_q & ~stall_if;
    assign free    = ~valid_q | consume;
    assign tgt     = {jump_target[31:2], 2'b00};

    assign imem_req      = (state_q == REQ) || (state_q == DROP);
    assign imem_addr     = (state_q == DROP) ? drop_addr_q : pc_q;
    assign inst_valid_if = valid_q;
    assign inst_if       = inst_q;
    assign pc_if         = opc_q;
    assign pc_add4_if    = opc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        valid_d     = valid_q & ~consume;
        inst_d      = inst_q;
        opc_d       = opc_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (jump_en) begin
                    pc_d    = tgt;
                    valid_d = 1'b0;
                end
            end
            REQ: begin
                if (jump_en) begin
                    pc_d    = tgt;
                    valid_d = 1'b0;
                    if (!imem_ack) begin
                        // outstanding request must still complete
                        drop_addr_d = pc_q;
                        state_d     = DROP;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_q + 32'd4;
                    if (free) begin
                        valid_d = 1'b1;
                        inst_d  = imem_rdata;
                        opc_d   = pc_q;
                    end else begin
                        skid_inst_d = imem_rdata;
                        skid_pc_d   = pc_q;
                        state_d     = SKID;
                    end
                end
            end
            SKID: begin
                if (jump_en) begin
                    pc_d    = tgt;
                    valid_d = 1'b0;
                    state_d = REQ;
                end else if (consume) begin
                    valid_d = 1'b1;
                    inst_d  = skid_inst_q;
                    opc_d   = skid_pc_q;
                    state_d = REQ;
                end
            end
            DROP: begin
                if (jump_en) begin
                    pc_d    = tgt;
                    valid_d = 1'b0;
                end
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            valid_q     <= 1'b0;
            inst_q      <= NOP;
            opc_q       <= RESET_PC;
            skid_inst_q <= NOP;
            skid_pc_q   <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            valid_q     <= valid_d;
            inst_q      <= inst_d;
            opc_q       <= opc_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

`ifdef FETCH_STAT_EN
    logic [31:0] fcnt_q, fcnt_d;
    logic [31:0] wcnt_q, wcnt_d;

    always_comb begin
        fcnt_d = fcnt_q;
        wcnt_d = wcnt_q;
        if (consume && !jump_en) begin
            fcnt_d = fcnt_q + 32'd1;
        end
        if (imem_req && !imem_ack) begin
            wcnt_d = wcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fcnt_q <= 32'd0;
            wcnt_q <= 32'd0;
        end else begin
            fcnt_q <= fcnt_d;
            wcnt_q <= wcnt_d;
        end
    end

    assign stat_fetch_cnt = fcnt_q;
    assign stat_wait_cnt  = wcnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl with a combinational memory model.
module tb_fetch_ctrl;

    logic        clk;
    logic        rstn;
    logic        stall_if;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid_if;
    logic [31:0] inst_if;
    logic [31:0] pc_if;
    logic [31:0] pc_add4_if;
`ifdef FETCH_STAT_EN
    logic [31:0] stat_fetch_cnt;
    logic [31:0] stat_wait_cnt;
    logic [31:0] w0;
`endif

    int checks = 0;
    int errors = 0;

    fetch_ctrl dut (
        .clk           (clk),
        .rstn          (rstn),
        .stall_if      (stall_if),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
`ifdef FETCH_STAT_EN
        .stat_fetch_cnt(stat_fetch_cnt),
        .stat_wait_cnt (stat_wait_cnt),
`endif
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst_valid_if (inst_valid_if),
        .inst_if       (inst_if),
        .pc_if         (pc_if),
        .pc_add4_if    (pc_add4_if)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] a;

    initial begin
        rstn        = 1'b0;
        stall_if    = 1'b0;
        jump_en     = 1'b0;
        jump_target = 32'h0;
        imem_ack    = 1'b1;
        repeat (2) step();
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_vld", {31'b0, inst_valid_if}, 32'd0);
        check("rst_inst", inst_if, 32'h0000_0013);
        check("rst_pc", pc_if, 32'h0040_0000);
        check("rst_pc4", pc_add4_if, 32'h0040_0004);

        // back-to-back zero-wait fetch
        rstn = 1'b1;
        step();
        check("b2b_req", {31'b0, imem_req}, 32'd1);
        check("b2b_addr0", imem_addr, 32'h0040_0000);
        check("b2b_vld0", {31'b0, inst_valid_if}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            a = 32'h0040_0000 + 32'(4 * i);
            check("b2b_vld", {31'b0, inst_valid_if}, 32'd1);
            check("b2b_pc", pc_if, a);
            check("b2b_inst", inst_if, mem_word(a));
            check("b2b_addr", imem_addr, a + 32'd4);
        end

        // three wait states at 0x0040_0010
        imem_ack = 1'b0;
`ifdef FETCH_STAT_EN
        w0 = stat_wait_cnt;
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_req", {31'b0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, 32'h0040_0010);
            check("wait_vld", {31'b0, inst_valid_if}, 32'd0);
        end
`ifdef FETCH_STAT_EN
        check("wait_cnt", stat_wait_cnt - w0, 32'd3);
`endif
        imem_ack = 1'b1;
        step();
        check("wait_vld1", {31'b0, inst_valid_if}, 32'd1);
        check("wait_inst", inst_if, mem_word(32'h0040_0010));
        check("wait_addr1", imem_addr, 32'h0040_0014);

        // two-cycle stall while 0x0040_0014 returns
        stall_if = 1'b1;
        step();
        check("skid_req", {31'b0, imem_req}, 32'd0);
        check("skid_pc", pc_if, 32'h0040_0010);
        step();
        check("skid_req2", {31'b0, imem_req}, 32'd0);
        check("skid_inst2", inst_if, mem_word(32'h0040_0010));
        stall_if = 1'b0;
        step();
        check("skid_vld", {31'b0, inst_valid_if}, 32'd1);
        check("skid_out_pc", pc_if, 32'h0040_0014);
        check("skid_out", inst_if, mem_word(32'h0040_0014));
        check("skid_addr", imem_addr, 32'h0040_0018);
        step();
        check("skid_next", pc_if, 32'h0040_0018);
        check("skid_addr2", imem_addr, 32'h0040_001C);

        // jump during a 2-wait request at 0x0040_001C
        imem_ack    = 1'b0;
        jump_en     = 1'b1;
        jump_target = 32'h0040_0103;
        step();
        jump_en = 1'b0;
        check("drop_vld", {31'b0, inst_valid_if}, 32'd0);
        check("drop_req", {31'b0, imem_req}, 32'd1);
        check("drop_addr", imem_addr, 32'h0040_001C);
        step();
        check("drop_addr2", imem_addr, 32'h0040_001C);
        imem_ack = 1'b1;
        step();
        check("drop_vld2", {31'b0, inst_valid_if}, 32'd0);
        check("jmp_addr", imem_addr, 32'h0040_0100);
        step();
        check("jmp_vld", {31'b0, inst_valid_if}, 32'd1);
        check("jmp_pc", pc_if, 32'h0040_0100);
        check("jmp_inst", inst_if, mem_word(32'h0040_0100));

        // jump with stall, target at top of address space
        stall_if    = 1'b1;
        jump_en     = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        step();
        stall_if = 1'b0;
        jump_en  = 1'b0;
        check("js_vld", {31'b0, inst_valid_if}, 32'd0);
        check("js_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_pc", pc_if, 32'hFFFF_FFFC);
        check("wrap_pc4", pc_add4_if, 32'h0000_0000);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        step();
        check("wrap_pc0", pc_if, 32'h0000_0000);
        check("wrap_inst", inst_if, mem_word(32'h0000_0000));

        // asynchronous reset in the middle of a cycle
        #2;
        rstn = 1'b0;
        #1;
        check("arst_req", {31'b0, imem_req}, 32'd0);
        check("arst_vld", {31'b0, inst_valid_if}, 32'd0);
        check("arst_pc", pc_if, 32'h0040_0000);
        step();
        check("arst_hold", {31'b0, imem_req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, meaning PC fetched first after reset.
REQ-002 clk  input  1  sole clock, all state rises on posedge clk.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 stall_if  input  1  from Hazard: downstream IF/ID not accepting this cycle.
REQ-005 jump_en  input  1  from EX: redirect (taken branch/jal/jalr), same condition that drives Hazard flush.
REQ-006 jump_target  input  32  redirect PC.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  32  request address.
REQ-009 imem_ack  input  1  memory returns imem_rdata this cycle; may be high in the same cycle req first rises (zero-wait).
REQ-010 imem_rdata  input  32  instruction word.
REQ-011 inst_valid_if  output  1  inst_if/pc_if hold a valid instruction.
REQ-012 inst_if  output  32  fetched instruction.
REQ-013 pc_if  output  32  PC of inst_if.
REQ-014 pc_add4_if  output  32  pc_if+4, combinational.

Function
REQ-015 States IDLE, REQ, SKID, DROP; internal pc_reg, 1-entry output buffer (inst_if/pc_if/inst_valid_if), 1-entry skid buffer.
REQ-016 Consume event = inst_valid_if & !stall_if; buffer "free" = !inst_valid_if or consume this cycle.
REQ-017 IDLE: imem_req=0; next cycle -> REQ unconditionally.
REQ-018 REQ: imem_req=1, imem_addr=pc_reg; req and addr held stable until ack (no retraction, no address change).
REQ-019 REQ & ack & free: load output buffer with imem_rdata/pc_reg, valid=1, pc_reg+=4, stay REQ (back-to-back, one instruction/cycle at zero-wait).
REQ-020 REQ & ack & !free: store word/PC in skid, pc_reg+=4, -> SKID.
REQ-021 REQ & !ack & consume: inst_valid_if<=0.
REQ-022 SKID: imem_req=0; on consume, move skid to output buffer (valid=1), -> REQ next cycle.
REQ-023 jump_en highest priority, overrides stall_if: pc_reg<=target with bits[1:0] forced 00; inst_valid_if<=0; skid discarded.
REQ-024 jump_en in REQ without ack: -> DROP; DROP keeps req high with old address until ack, discards returned data, then -> REQ at new pc_reg.
REQ-025 jump_en in REQ with ack, or in SKID/IDLE/DROP: returned/skid data discarded; from DROP with ack or REQ/SKID -> REQ; DROP without ack stays DROP; second jump in DROP only updates pc_reg.
REQ-026 pc arithmetic modulo 2^32: 32'hFFFF_FFFC+4 = 0; pc_add4_if wraps likewise.
REQ-027 No instruction ever delivered twice, dropped, or reordered absent jump_en.

Reset
REQ-028 rstn low asynchronously forces: state IDLE, imem_req=0, pc_reg=RESET_PC, inst_valid_if=0, inst_if=32'h0000_0013 (NOP), pc_if=RESET_PC, skid empty.
REQ-029 Reset mid-request abandons transaction; any ack during reset ignored.

Configuration
REQ-030 Macro FETCH_STAT_EN defined: adds outputs stat_fetch_cnt[31:0] (+1 per consume without jump_en) and stat_wait_cnt[31:0] (+1 per cycle imem_req & !imem_ack), both reset to 0, wrapping.
REQ-031 FETCH_STAT_EN undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-032 Reset release, ack tied 1, stall 0 -> imem_addr 0x0040_0000, 0x0040_0004, ... each cycle; inst_if matches memory, valid continuous.
REQ-033 Ack delayed 3 cycles -> req/addr stable 3 cycles, valid low meanwhile; stat_wait_cnt=3 with FETCH_STAT_EN.
REQ-034 stall_if high 2 cycles while ack arrives -> SKID entered, word delivered after stall drops, no loss/duplication.
REQ-035 jump_en target 0x0040_0103 during pending 2-wait request -> old word discarded, next addr 0x0040_0100.
REQ-036 jump_en and stall_if same cycle -> valid cleared, fetch at target; pc 0xFFFF_FFFC -> next addr 0x0000_0000, pc_add4_if 0x0000_0000.
